// File: rtl/conv_window_addr.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_addr
//  Description : Convolution read-address generator for the feature-map SRAM.
//                Walks every kernel tap (kx innermost, then ky, channel,
//                output x, output y) of every output window and emits one
//                SRAM word address per cycle over a valid/ready handshake.
//                Window and channel boundaries are flagged for the MAC path.
//
//  Ports       : clk, rst_n            clock, async active-low reset
//                i_start               start pulse (sampled only when idle)
//                i_base_addr           address of pixel (0,0), channel 0
//                i_img_w / i_img_h     image size in pixels
//                i_k                   square kernel size
//                i_stride              window stride (1..3)
//                i_channels            input channel count
//                i_ready               downstream accepts o_addr
//                o_valid / o_addr      tap address stream
//                o_end_kernel          last tap of the window for a channel
//                o_end_window          last tap of last channel of a window
//                o_busy                job in progress (incl. done cycle)
//                o_done / o_err        end-of-job pulse, err = illegal config
//                i_pad / o_pad         only with CONV_ADDR_PAD_EN defined:
//                                      zero-padding amount and pad-tap flag
//
//  Optional    : `define CONV_ADDR_PAD_EN to enable zero-padding support.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_window_addr #(
    parameter int ADDR_WIDTH = 18,
    parameter int DIM_WIDTH  = 10,
    parameter int K_WIDTH    = 3,
    parameter int CH_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [DIM_WIDTH-1:0]  i_img_w,
    input  logic [DIM_WIDTH-1:0]  i_img_h,
    input  logic [K_WIDTH-1:0]    i_k,
    input  logic [1:0]            i_stride,
    input  logic [CH_WIDTH-1:0]   i_channels,
`ifdef CONV_ADDR_PAD_EN
    input  logic [1:0]            i_pad,
    output logic                  o_pad,
`endif
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_end_kernel,
    output logic                  o_end_window,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    // Coordinate width in padded image space: image size + 2*pad + stride + k
    // must fit without overflow.
    localparam int CW = DIM_WIDTH + 3;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_RUN  = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;
    localparam logic [1:0] C_ST_ERR  = 2'd3;

    // Multiply by a 2-bit constant using shift/add; used for pad and stride
    // row steps at job start only.
    function automatic logic [ADDR_WIDTH-1:0] mul_small(
        input logic [ADDR_WIDTH-1:0] x,
        input logic [1:0]            m
    );
        logic [ADDR_WIDTH-1:0] r;
        case (m)
            2'd0:    r = '0;
            2'd1:    r = x;
            2'd2:    r = x << 1;
            default: r = x + (x << 1);
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State, latched configuration and walk counters
    // ------------------------------------------------------------------
    logic [1:0]            state_q,      state_d;
    logic [DIM_WIDTH-1:0]  cfg_w_q,      cfg_w_d;
    logic [DIM_WIDTH-1:0]  cfg_h_q,      cfg_h_d;
    logic [K_WIDTH-1:0]    cfg_k_q,      cfg_k_d;
    logic [1:0]            cfg_stride_q, cfg_stride_d;
    logic [CH_WIDTH-1:0]   cfg_ch_q,     cfg_ch_d;
    logic [1:0]            cfg_pad_q,    cfg_pad_d;
    logic [ADDR_WIDTH-1:0] plane_q,      plane_d;     // img_w*img_h
    logic [ADDR_WIDTH-1:0] rowstep_q,    rowstep_d;   // stride*img_w

    logic [K_WIDTH-1:0]    kx_q,      kx_d;
    logic [K_WIDTH-1:0]    ky_q,      ky_d;
    logic [CH_WIDTH-1:0]   ch_q,      ch_d;
    logic [CW-1:0]         wx_q,      wx_d;       // window origin x (padded space)
    logic [CW-1:0]         wy_q,      wy_d;       // window origin y (padded space)
    logic [ADDR_WIDTH-1:0] row_ptr_q, row_ptr_d;  // start of current tap row
    logic [ADDR_WIDTH-1:0] chwin_q,   chwin_d;    // window origin, current channel
    logic [ADDR_WIDTH-1:0] win_q,     win_d;      // window origin, channel 0
    logic [ADDR_WIDTH-1:0] rowbase_q, rowbase_d;  // origin of first window in row

    logic                  valid_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  endk_q;
    logic                  endw_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    // ------------------------------------------------------------------
    // Start-time configuration decode
    // ------------------------------------------------------------------
    logic [1:0]            w_pad_in;
    logic [CW-1:0]         w_weff_in;
    logic [CW-1:0]         w_heff_in;
    logic                  w_cfg_ok;
    logic [ADDR_WIDTH-1:0] w_plane_in;
    logic [ADDR_WIDTH-1:0] w_origin_in;

`ifdef CONV_ADDR_PAD_EN
    assign w_pad_in = i_pad;
`else
    assign w_pad_in = 2'b00;
`endif

    assign w_weff_in = CW'(i_img_w) + CW'({w_pad_in, 1'b0});
    assign w_heff_in = CW'(i_img_h) + CW'({w_pad_in, 1'b0});

    assign w_cfg_ok = (i_k != '0) && (i_stride != 2'd0) && (i_channels != '0) &&
                      (CW'(i_k) <= w_weff_in) && (CW'(i_k) <= w_heff_in);

    // The only multiplier in the block; its result is captured once per job.
    assign w_plane_in = ADDR_WIDTH'(i_img_w) * ADDR_WIDTH'(i_img_h);

    // Padded origin sits pad rows above and pad columns left of pixel (0,0).
    // Wrapping is harmless: taps that would land outside the image are
    // reported as pad taps with the address forced to zero.
    assign w_origin_in = i_base_addr - mul_small(ADDR_WIDTH'(i_img_w), w_pad_in)
                                     - ADDR_WIDTH'(w_pad_in);

    // ------------------------------------------------------------------
    // Loop-boundary detection on the tap currently presented
    // ------------------------------------------------------------------
    logic          w_kx_last;
    logic          w_ky_last;
    logic          w_ch_last;
    logic          w_ox_last;
    logic          w_oy_last;
    logic [CW-1:0] w_weff_q;
    logic [CW-1:0] w_heff_q;

    assign w_weff_q  = CW'(cfg_w_q) + CW'({cfg_pad_q, 1'b0});
    assign w_heff_q  = CW'(cfg_h_q) + CW'({cfg_pad_q, 1'b0});
    assign w_kx_last = (kx_q == cfg_k_q - K_WIDTH'(1));
    assign w_ky_last = (ky_q == cfg_k_q - K_WIDTH'(1));
    assign w_ch_last = (ch_q == cfg_ch_q - CH_WIDTH'(1));
    // Last window in a row/column when the next stride step would not fit.
    assign w_ox_last = (wx_q + CW'(cfg_stride_q) + CW'(cfg_k_q)) > w_weff_q;
    assign w_oy_last = (wy_q + CW'(cfg_stride_q) + CW'(cfg_k_q)) > w_heff_q;

    // ------------------------------------------------------------------
    // Next-state: FSM and incremental address walk
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cfg_w_d      = cfg_w_q;
        cfg_h_d      = cfg_h_q;
        cfg_k_d      = cfg_k_q;
        cfg_stride_d = cfg_stride_q;
        cfg_ch_d     = cfg_ch_q;
        cfg_pad_d    = cfg_pad_q;
        plane_d      = plane_q;
        rowstep_d    = rowstep_q;
        kx_d         = kx_q;
        ky_d         = ky_q;
        ch_d         = ch_q;
        wx_d         = wx_q;
        wy_d         = wy_q;
        row_ptr_d    = row_ptr_q;
        chwin_d      = chwin_q;
        win_d        = win_q;
        rowbase_d    = rowbase_q;

        case (state_q)
            C_ST_IDLE: begin
                if (i_start) begin
                    cfg_w_d      = i_img_w;
                    cfg_h_d      = i_img_h;
                    cfg_k_d      = i_k;
                    cfg_stride_d = i_stride;
                    cfg_ch_d     = i_channels;
                    cfg_pad_d    = w_pad_in;
                    plane_d      = w_plane_in;
                    rowstep_d    = mul_small(ADDR_WIDTH'(i_img_w), i_stride);
                    kx_d         = '0;
                    ky_d         = '0;
                    ch_d         = '0;
                    wx_d         = '0;
                    wy_d         = '0;
                    row_ptr_d    = w_origin_in;
                    chwin_d      = w_origin_in;
                    win_d        = w_origin_in;
                    rowbase_d    = w_origin_in;
                    state_d      = w_cfg_ok ? C_ST_RUN : C_ST_ERR;
                end
            end

            // o_valid is always high in RUN, so i_ready alone marks a transfer.
            C_ST_RUN: begin
                if (i_ready) begin
                    if (!w_kx_last) begin
                        kx_d = kx_q + K_WIDTH'(1);
                    end else begin
                        kx_d = '0;
                        if (!w_ky_last) begin
                            ky_d      = ky_q + K_WIDTH'(1);
                            row_ptr_d = row_ptr_q + ADDR_WIDTH'(cfg_w_q);
                        end else begin
                            ky_d = '0;
                            if (!w_ch_last) begin
                                ch_d      = ch_q + CH_WIDTH'(1);
                                chwin_d   = chwin_q + plane_q;
                                row_ptr_d = chwin_d;
                            end else begin
                                ch_d = '0;
                                if (!w_ox_last) begin
                                    wx_d      = wx_q + CW'(cfg_stride_q);
                                    win_d     = win_q + ADDR_WIDTH'(cfg_stride_q);
                                    chwin_d   = win_d;
                                    row_ptr_d = win_d;
                                end else if (!w_oy_last) begin
                                    wx_d      = '0;
                                    wy_d      = wy_q + CW'(cfg_stride_q);
                                    rowbase_d = rowbase_q + rowstep_q;
                                    win_d     = rowbase_d;
                                    chwin_d   = rowbase_d;
                                    row_ptr_d = rowbase_d;
                                end else begin
                                    state_d = C_ST_DONE;
                                end
                            end
                        end
                    end
                end
            end

            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode for the next presented tap
    // ------------------------------------------------------------------
    logic [CW-1:0]         w_px;
    logic [CW-1:0]         w_py;
    logic                  w_tap_pad;
    logic [ADDR_WIDTH-1:0] w_addr_d;
    logic                  w_endk_d;
    logic                  w_endw_d;
    logic                  w_run_d;

    assign w_px = wx_d + CW'(kx_d);
    assign w_py = wy_d + CW'(ky_d);

    // Padded-space tap lies in the border ring of width pad.
    assign w_tap_pad = (w_px <  CW'(cfg_pad_d)) ||
                       (w_px >= CW'(cfg_w_d) + CW'(cfg_pad_d)) ||
                       (w_py <  CW'(cfg_pad_d)) ||
                       (w_py >= CW'(cfg_h_d) + CW'(cfg_pad_d));

    assign w_addr_d = w_tap_pad ? '0 : (row_ptr_d + ADDR_WIDTH'(kx_d));
    assign w_endk_d = (kx_d == cfg_k_d - K_WIDTH'(1)) && (ky_d == cfg_k_d - K_WIDTH'(1));
    assign w_endw_d = w_endk_d && (ch_d == cfg_ch_d - CH_WIDTH'(1));
    assign w_run_d  = (state_d == C_ST_RUN);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= C_ST_IDLE;
            cfg_w_q      <= '0;
            cfg_h_q      <= '0;
            cfg_k_q      <= '0;
            cfg_stride_q <= '0;
            cfg_ch_q     <= '0;
            cfg_pad_q    <= '0;
            plane_q      <= '0;
            rowstep_q    <= '0;
            kx_q         <= '0;
            ky_q         <= '0;
            ch_q         <= '0;
            wx_q         <= '0;
            wy_q         <= '0;
            row_ptr_q    <= '0;
            chwin_q      <= '0;
            win_q        <= '0;
            rowbase_q    <= '0;
            valid_q      <= 1'b0;
            addr_q       <= '0;
            endk_q       <= 1'b0;
            endw_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_w_q      <= cfg_w_d;
            cfg_h_q      <= cfg_h_d;
            cfg_k_q      <= cfg_k_d;
            cfg_stride_q <= cfg_stride_d;
            cfg_ch_q     <= cfg_ch_d;
            cfg_pad_q    <= cfg_pad_d;
            plane_q      <= plane_d;
            rowstep_q    <= rowstep_d;
            kx_q         <= kx_d;
            ky_q         <= ky_d;
            ch_q         <= ch_d;
            wx_q         <= wx_d;
            wy_q         <= wy_d;
            row_ptr_q    <= row_ptr_d;
            chwin_q      <= chwin_d;
            win_q        <= win_d;
            rowbase_q    <= rowbase_d;
            valid_q      <= w_run_d;
            addr_q       <= w_run_d ? w_addr_d : '0;
            endk_q       <= w_run_d && w_endk_d;
            endw_q       <= w_run_d && w_endw_d;
            busy_q       <= (state_d != C_ST_IDLE);
            done_q       <= (state_d == C_ST_DONE) || (state_d == C_ST_ERR);
            err_q        <= (state_d == C_ST_ERR);
        end
    end

`ifdef CONV_ADDR_PAD_EN
    logic pad_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_q <= 1'b0;
        end else begin
            pad_q <= w_run_d && w_tap_pad;
        end
    end

    assign o_pad = pad_q;
`endif

    assign o_valid      = valid_q;
    assign o_addr       = addr_q;
    assign o_end_kernel = endk_q;
    assign o_end_window = endw_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_addr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_window_addr
//  Description : Self-checking bench for conv_window_addr. Stimulus pushes
//                expected taps into a queue; a monitor pops and compares on
//                every handshake and checks stability under back-pressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_addr;

    localparam int AW  = 18;
    localparam int DW  = 10;
    localparam int KW  = 3;
    localparam int CHW = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_start = 1'b0;
    logic [AW-1:0]  i_base_addr = '0;
    logic [DW-1:0]  i_img_w = '0;
    logic [DW-1:0]  i_img_h = '0;
    logic [KW-1:0]  i_k = '0;
    logic [1:0]     i_stride = '0;
    logic [CHW-1:0] i_channels = '0;
    logic           i_ready = 1'b1;
    logic           o_valid;
    logic [AW-1:0]  o_addr;
    logic           o_end_kernel;
    logic           o_end_window;
    logic           o_busy;
    logic           o_done;
    logic           o_err;
`ifdef CONV_ADDR_PAD_EN
    logic [1:0]     i_pad = 2'd0;
    logic           o_pad;
`endif

    conv_window_addr #(
        .ADDR_WIDTH (AW),
        .DIM_WIDTH  (DW),
        .K_WIDTH    (KW),
        .CH_WIDTH   (CHW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_img_w      (i_img_w),
        .i_img_h      (i_img_h),
        .i_k          (i_k),
        .i_stride     (i_stride),
        .i_channels   (i_channels),
`ifdef CONV_ADDR_PAD_EN
        .i_pad        (i_pad),
        .o_pad        (o_pad),
`endif
        .i_ready      (i_ready),
        .o_valid      (o_valid),
        .o_addr       (o_addr),
        .o_end_kernel (o_end_kernel),
        .o_end_window (o_end_window),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          ek;
        logic          ew;
        logic          pd;
    } exp_t;

    exp_t          exp_q[$];
    int            total = 0;
    int            bad = 0;
    int            n_xfer = 0;
    int            cyc = 0;
    int            last_xfer_cyc = 0;
    logic [AW-1:0] seen_addr [0:127];
    logic          seen_pad  [0:127];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops one expected tap per handshake
    // ------------------------------------------------------------------
    initial begin : monitor
        logic          stalled;
        logic [AW-1:0] held_addr;
        logic [1:0]    held_flags;
        exp_t          e;
        stalled = 1'b0;
        held_addr = '0;
        held_flags = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else if (o_valid) begin
                if (stalled) begin
                    chk("stall_addr", 32'(o_addr), 32'(held_addr));
                    chk("stall_flags", 32'({o_end_kernel, o_end_window}), 32'(held_flags));
                end
                if (i_ready) begin
                    if (n_xfer < 128) begin
                        seen_addr[n_xfer] = o_addr;
`ifdef CONV_ADDR_PAD_EN
                        seen_pad[n_xfer] = o_pad;
`else
                        seen_pad[n_xfer] = 1'b0;
`endif
                    end
                    n_xfer++;
                    last_xfer_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_xfer: got addr %0d, expected no transfer", o_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("addr", 32'(o_addr), 32'(e.addr));
                        chk("end_kernel", 32'(o_end_kernel), 32'(e.ek));
                        chk("end_window", 32'(o_end_window), 32'(e.ew));
`ifdef CONV_ADDR_PAD_EN
                        chk("pad", 32'(o_pad), 32'(e.pd));
`endif
                    end
                    stalled = 1'b0;
                end else begin
                    stalled    = 1'b1;
                    held_addr  = o_addr;
                    held_flags = {o_end_kernel, o_end_window};
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // Hand-computed 4x4, k=3, stride 1, 1 channel, base 0 sequence.
    task automatic push_case1();
        int   tab [36];
        exp_t e;
        tab = '{0, 1, 2, 4, 5, 6, 8, 9, 10,
                1, 2, 3, 5, 6, 7, 9, 10, 11,
                4, 5, 6, 8, 9, 10, 12, 13, 14,
                5, 6, 7, 9, 10, 11, 13, 14, 15};
        for (int i = 0; i < 36; i++) begin
            e.addr = AW'(tab[i]);
            e.ek   = ((i % 9) == 8);
            e.ew   = ((i % 9) == 8);
            e.pd   = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // Direct-formula reference for larger jobs.
    task automatic push_model(input int base, input int w, input int h, input int k,
                              input int s, input int ch, input int pad);
        int   ow;
        int   oh;
        int   px;
        int   py;
        exp_t e;
        ow = (w + 2 * pad - k) / s + 1;
        oh = (h + 2 * pad - k) / s + 1;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int c = 0; c < ch; c++)
                    for (int ky = 0; ky < k; ky++)
                        for (int kx = 0; kx < k; kx++) begin
                            px     = ox * s + kx - pad;
                            py     = oy * s + ky - pad;
                            e.pd   = (px < 0) || (px >= w) || (py < 0) || (py >= h);
                            e.addr = e.pd ? '0 : AW'(base + c * w * h + py * w + px);
                            e.ek   = (kx == k - 1) && (ky == k - 1);
                            e.ew   = e.ek && (c == ch - 1);
                            exp_q.push_back(e);
                        end
    endtask

    task automatic start_job(input int base, input int w, input int h, input int k,
                             input int s, input int ch);
        @(posedge clk); #1;
        i_base_addr = AW'(base);
        i_img_w     = DW'(w);
        i_img_h     = DW'(h);
        i_k         = KW'(k);
        i_stride    = 2'(s);
        i_channels  = CHW'(ch);
        i_start     = 1'b1;
        @(posedge clk); #1;
        i_start     = 1'b0;
    endtask

    task automatic run_to_done(input string nm, input int exp_n, input bit rnd);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (o_done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        i_ready = 1'b1;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no o_done, expected o_done within 600 cycles", nm);
        end else begin
            chk({nm, "_done_valid"}, 32'(o_valid), 0);
            chk({nm, "_done_busy"},  32'(o_busy), 1);
            chk({nm, "_done_err"},   32'(o_err), 0);
            chk({nm, "_count"},      32'(n_xfer), 32'(exp_n));
            chk({nm, "_done_lat"},   32'(cyc), 32'(last_xfer_cyc + 1));
            chk({nm, "_leftover"},   32'(exp_q.size()), 0);
            @(negedge clk);
            chk({nm, "_done_pulse"}, 32'(o_done), 0);
            chk({nm, "_idle_busy"},  32'(o_busy), 0);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1);
    end

    initial begin : stim
        bit hit;
        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_flags", 32'({o_valid, o_end_kernel, o_end_window, o_busy, o_done, o_err}), 0);
        chk("rst_addr", 32'(o_addr), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(o_busy), 0);

        // ---------------- case 1: 4x4 k3 s1 ----------------
        n_xfer = 0;
        push_case1();
        start_job(0, 4, 4, 3, 1, 1);
        @(negedge clk);
        chk("c1_first_valid", 32'(o_valid), 1);
        chk("c1_first_busy", 32'(o_busy), 1);
        run_to_done("c1", 36, 1'b0);
        chk("c1_endk0", 32'(seen_addr[8]), 10);
        chk("c1_endk1", 32'(seen_addr[17]), 11);
        chk("c1_endk2", 32'(seen_addr[26]), 14);
        chk("c1_endk3", 32'(seen_addr[35]), 15);

        // ---------------- case 2: 5x5 k3 s2, 2 ch, base 100 ----------------
        n_xfer = 0;
        push_model(100, 5, 5, 3, 2, 2, 0);
        start_job(100, 5, 5, 3, 2, 2);
        run_to_done("c2", 72, 1'b0);
        chk("c2_first", 32'(seen_addr[0]), 100);
        chk("c2_w0_last", 32'(seen_addr[8]), 112);
        chk("c2_w1_ch1", 32'(seen_addr[27]), 127);

        // ---------------- case 3: back-pressure ----------------
        n_xfer = 0;
        push_case1();
        start_job(0, 4, 4, 3, 1, 1);
        run_to_done("c3", 36, 1'b1);

        // ---------------- case 4: illegal config, start during RUN ----------------
        n_xfer = 0;
        start_job(0, 4, 4, 5, 1, 1);
        @(negedge clk);
        chk("err_done", 32'(o_done), 1);
        chk("err_err", 32'(o_err), 1);
        chk("err_valid", 32'(o_valid), 0);
        @(negedge clk);
        chk("err_clear", 32'({o_done, o_err, o_busy}), 0);

        n_xfer = 0;
        push_case1();
        start_job(0, 4, 4, 3, 1, 1);
        repeat (5) @(posedge clk);
        #1;
        i_base_addr = AW'(500);
        i_k         = KW'(2);
        i_stride    = 2'd2;
        i_start     = 1'b1;
        @(posedge clk); #1;
        i_start     = 1'b0;
        run_to_done("c4", 36, 1'b0);

        // ---------------- case 5: reset after 7th transfer ----------------
        n_xfer = 0;
        push_case1();
        start_job(0, 4, 4, 3, 1, 1);
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (n_xfer == 7) begin
                hit = 1'b1;
                break;
            end
        end
        chk("c5_reach7", 32'(hit), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("c5_abort_flags", 32'({o_valid, o_end_kernel, o_end_window, o_busy, o_done, o_err}), 0);
        chk("c5_abort_addr", 32'(o_addr), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("c5_no_done", 32'({o_done, o_busy}), 0);
        n_xfer = 0;
        push_case1();
        start_job(0, 4, 4, 3, 1, 1);
        run_to_done("c5", 36, 1'b0);

`ifdef CONV_ADDR_PAD_EN
        // ---------------- case 6: 3x3 k3 pad1 s1 ----------------
        n_xfer = 0;
        i_pad = 2'd1;
        push_model(0, 3, 3, 3, 1, 1, 1);
        start_job(0, 3, 3, 3, 1, 1);
        run_to_done("c6", 81, 1'b0);
        i_pad = 2'd0;
        chk("c6_pads", 32'({seen_pad[0], seen_pad[1], seen_pad[2], seen_pad[3], seen_pad[4],
                            seen_pad[5], seen_pad[6], seen_pad[7], seen_pad[8]}), 32'h1E4);
        chk("c6_t4", 32'(seen_addr[4]), 0);
        chk("c6_t5", 32'(seen_addr[5]), 1);
        chk("c6_t7", 32'(seen_addr[7]), 3);
        chk("c6_t8", 32'(seen_addr[8]), 4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
